// File: rtl/simplenet_weight_loader.sv
// rtl/simplenet_weight_loader.sv - serial weight loader with shadow/active banks for simpleNet
// Assembles NUM_W weights in a shadow bank and commits them atomically to the active bank.
module simplenet_weight_loader #(
  parameter int W_WIDTH = 4,
  parameter int NUM_W   = 9,
  parameter int ERR_W   = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clear_i,
  input  logic                       wr_valid_i,
  input  logic                       wr_sof_i,
  input  logic [W_WIDTH-1:0]         wr_data_i,
  output logic                       wr_ready_o,
  output logic [NUM_W*W_WIDTH-1:0]   w_flat_o,
  output logic                       weights_valid_o,
  output logic                       commit_pulse_o,
  output logic [ERR_W-1:0]           err_count_o
);

  localparam int IDX_W = $clog2(NUM_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMMIT
  } state_e;

  state_e                     state_q;
  logic [IDX_W-1:0]           idx_q;
  logic [NUM_W*W_WIDTH-1:0]   shadow_q;
  logic [NUM_W*W_WIDTH-1:0]   active_q;
  logic                       valid_q;
  logic                       pulse_q;
  logic [ERR_W-1:0]           err_q;
  logic [ERR_W-1:0]           err_d;
  logic                       xfer;

  assign wr_ready_o = (state_q != COMMIT);
  assign xfer       = wr_valid_i && wr_ready_o;
  assign err_d      = (&err_q) ? err_q : err_q + 1'b1;

  assign w_flat_o        = active_q;
  assign weights_valid_o = valid_q;
  assign commit_pulse_o  = pulse_q;
  assign err_count_o     = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
      err_q    <= '0;
    end else if (clear_i) begin
      // err_q deliberately survives clear so protocol history is not lost
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      valid_q  <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (xfer) begin
            if (wr_sof_i) begin
              shadow_q[W_WIDTH-1:0] <= wr_data_i;
              idx_q                 <= IDX_W'(1);
              state_q               <= LOAD;
            end else begin
              err_q <= err_d;
            end
          end
        end
        LOAD: begin
          if (xfer) begin
            if (wr_sof_i) begin
              shadow_q[W_WIDTH-1:0] <= wr_data_i;
              idx_q                 <= IDX_W'(1);
              err_q                 <= err_d;
            end else begin
              shadow_q[int'(idx_q)*W_WIDTH +: W_WIDTH] <= wr_data_i;
              if (idx_q == LAST_IDX) begin
                idx_q   <= '0;
                state_q <= COMMIT;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
        end
        COMMIT: begin
          active_q <= shadow_q;
          valid_q  <= 1'b1;
          pulse_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_simplenet_weight_loader.sv
// tb/tb_simplenet_weight_loader.sv - directed self-checking bench for simplenet_weight_loader
module tb_simplenet_weight_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_sof = 1'b0;
  logic [3:0]  wr_data = '0;
  logic        wr_ready;
  logic [35:0] w_flat;
  logic        weights_valid;
  logic        commit_pulse;
  logic [3:0]  err_count;

  int checks = 0;
  int errors = 0;

  localparam logic [35:0] FRAME_A = 36'h1E2322122;
  localparam logic [35:0] FRAME_B = 36'h876543215;
  localparam logic [35:0] FRAME_C = 36'h7A6B5C4D3;

  always #5 clk = ~clk;

  simplenet_weight_loader dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clear_i         (clear),
    .wr_valid_i      (wr_valid),
    .wr_sof_i        (wr_sof),
    .wr_data_i       (wr_data),
    .wr_ready_o      (wr_ready),
    .w_flat_o        (w_flat),
    .weights_valid_o (weights_valid),
    .commit_pulse_o  (commit_pulse),
    .err_count_o     (err_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One word; waits (bounded) for ready, returns 1ns after the accepting edge.
  task automatic send(input logic sof, input logic [3:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1;
    wr_sof   = sof;
    wr_data  = d;
    while (!wr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 10) check("ready_timeout", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [35:0] f);
    for (int i = 0; i < 9; i++) send(i == 0, f[4*i +: 4]);
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_w_flat", 64'(w_flat), 64'd0);
    check("rst_valid", 64'(weights_valid), 64'd0);
    check("rst_pulse", 64'(commit_pulse), 64'd0);
    check("rst_err", 64'(err_count), 64'd0);
    check("rst_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1+2: frame A, then hold the next sof word through COMMIT
    send_frame(FRAME_A);
    check("t1_commit_ready", 64'(wr_ready), 64'd0);
    check("t1_not_yet_valid", 64'(weights_valid), 64'd0);
    wr_valid = 1'b1; wr_sof = 1'b1; wr_data = FRAME_B[3:0];
    @(posedge clk); #1;
    check("t1_w_flat", 64'(w_flat), 64'(FRAME_A));
    check("t1_valid", 64'(weights_valid), 64'd1);
    check("t1_pulse_hi", 64'(commit_pulse), 64'd1);
    check("t2_ready_back", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_sof = 1'b0;
    check("t1_pulse_lo", 64'(commit_pulse), 64'd0);
    for (int i = 1; i < 9; i++) send(1'b0, FRAME_B[4*i +: 4]);
    check("t2_hold_a", 64'(w_flat), 64'(FRAME_A));
    @(posedge clk); #1;
    check("t2_w_flat_b", 64'(w_flat), 64'(FRAME_B));
    check("t2_err", 64'(err_count), 64'd0);

    // 3: orphan words in IDLE
    repeat (3) send(1'b0, 4'h9);
    check("t3_err", 64'(err_count), 64'd3);
    check("t3_w_flat", 64'(w_flat), 64'(FRAME_B));
    check("t3_valid", 64'(weights_valid), 64'd1);

    // 4: partial set aborted by a new sof, then full set C
    send(1'b1, 4'h9);
    repeat (3) send(1'b0, 4'h9);
    check("t4_partial_hold", 64'(w_flat), 64'(FRAME_B));
    send_frame(FRAME_C);
    check("t4_err_inc", 64'(err_count), 64'd4);
    check("t4_hold_b", 64'(w_flat), 64'(FRAME_B));
    @(posedge clk); #1;
    check("t4_w_flat_c", 64'(w_flat), 64'(FRAME_C));
    check("t4_pulse", 64'(commit_pulse), 64'd1);

    // 5: async reset mid-frame
    send(1'b1, 4'h1);
    repeat (4) send(1'b0, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_w_flat", 64'(w_flat), 64'd0);
    check("t5_valid", 64'(weights_valid), 64'd0);
    check("t5_err", 64'(err_count), 64'd0);
    check("t5_ready", 64'(wr_ready), 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(FRAME_A);
    @(posedge clk); #1;
    check("t5_w_flat_a", 64'(w_flat), 64'(FRAME_A));
    check("t5_valid_a", 64'(weights_valid), 64'd1);

    // 6: clear, saturation, clear keeps err, clear beats commit
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t6_clr_w_flat", 64'(w_flat), 64'd0);
    check("t6_clr_valid", 64'(weights_valid), 64'd0);
    repeat (15) send(1'b0, 4'h3);
    check("t6_err_15", 64'(err_count), 64'd15);
    repeat (5) send(1'b0, 4'h3);
    check("t6_err_sat", 64'(err_count), 64'd15);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t6_err_kept", 64'(err_count), 64'd15);
    send_frame(FRAME_C);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("t6_clr_commit_valid", 64'(weights_valid), 64'd0);
    check("t6_clr_commit_pulse", 64'(commit_pulse), 64'd0);
    check("t6_clr_commit_flat", 64'(w_flat), 64'd0);
    check("t6_clr_ready", 64'(wr_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
